// File: rtl/param_dff_reg.sv
// Universal register: hold, parallel load, shift, rotate, and sync clear/fill.
// Asynchronous reset and preset are included, with a saturating shift counter.
module param_dff_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         set,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin,
  output logic [WIDTH-1:0]             q_out,
  output logic [WIDTH-1:0]             qcomp_out,
  output logic                         sout_msb,
  output logic                         sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         full
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_FILL = 3'b111
  } op_t;

  op_t              op;
  logic             async_ctl;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic             full_reg;
  logic             full_nxt;

  assign op        = op_t'(mode);
  assign async_ctl = reset | set;
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  always_comb begin
    q_nxt   = q_reg;
    cnt_nxt = cnt_reg;
    if (en) begin
      unique case (op)
        OP_HOLD: ;
        OP_LOAD: begin q_nxt = d;                              cnt_nxt = '0;      end
        OP_SHL:  begin q_nxt = {q_reg[WIDTH-2:0], sin};        cnt_nxt = cnt_inc; end
        OP_SHR:  begin q_nxt = {sin, q_reg[WIDTH-1:1]};        cnt_nxt = cnt_inc; end
        OP_ROL:  q_nxt = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        OP_ROR:  q_nxt = {q_reg[0], q_reg[WIDTH-1:1]};
        OP_CLR:  begin q_nxt = '0;                             cnt_nxt = '0;      end
        OP_FILL: begin q_nxt = '1;                             cnt_nxt = '0;      end
        default: ;
      endcase
    end
    full_nxt = (cnt_nxt == CNT_MAX);
  end

  // The register tracks reset/set priority while either is held. A falling reset
  // under a held set has no edge, so the output mux below gives SET_VAL at once
  // and the register picks it up on the next clock while set is still high.
  always_ff @(posedge clk or posedge async_ctl) begin
    if (async_ctl) begin
      q_reg    <= reset ? RESET_VAL : SET_VAL;
      cnt_reg  <= '0;
      full_reg <= 1'b0;
    end else begin
      q_reg    <= q_nxt;
      cnt_reg  <= cnt_nxt;
      full_reg <= full_nxt;
    end
  end

  assign q_out     = reset ? RESET_VAL : (set ? SET_VAL : q_reg);
  assign qcomp_out = ~q_out;
  assign sout_msb  = q_out[WIDTH-1];
  assign sout_lsb  = q_out[0];
  assign shift_cnt = cnt_reg;
  assign full      = full_reg;

endmodule

// File: doc/param_dff_reg.md
# param_dff_reg

Parametrised universal register with asynchronous reset and set and a synchronous mode control. It provides hold, parallel load, shift, rotate and synchronous clear and fill operations. A saturating shift counter flags when a full word has been shifted in. It sits in the FlipFlops library as the multi-bit, multi-mode generalisation of the single-bit async D flip-flop, for use as a pipeline register, SIPO/PISO converter or rotating mask.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RESET_VAL, {WIDTH{1'b0}}, value forced by `reset`
- SET_VAL, {WIDTH{1'b1}}, value forced by `set`

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- set  in  1  asynchronous, active-high preset; lower priority than `reset`
- en  in  1  synchronous enable; when 0 all state holds
- mode  in  3  operation select (see Operation)
- d  in  WIDTH  parallel load data
- sin  in  1  serial input for shift modes
- q_out  out  WIDTH  register contents
- qcomp_out  out  WIDTH  combinational ~q_out
- sout_msb  out  1  q_out[WIDTH-1]
- sout_lsb  out  1  q_out[0]
- shift_cnt  out  $clog2(WIDTH+1)  shifts since last load/clear/reset, saturating at WIDTH
- full  out  1  registered; 1 when shift_cnt == WIDTH

## Operation
- Priority: reset > set > (en & mode) > hold.
- reset high: q_out = RESET_VAL, shift_cnt = 0, full = 0, immediately and independent of clk. State holds while reset is high.
- set high (reset low): q_out = SET_VAL, shift_cnt = 0, full = 0, immediately. State holds while set is high.
- en = 0 at a clock edge: q_out, shift_cnt and full hold.
- mode, applied at the rising clk edge when en = 1:
  - 000 hold. Nothing changes.
  - 001 load. q_out = d; shift_cnt = 0.
  - 010 shift left. q_out = {q_out[WIDTH-2:0], sin}; shift_cnt += 1, saturating.
  - 011 shift right. q_out = {sin, q_out[WIDTH-1:1]}; shift_cnt += 1, saturating.
  - 100 rotate left. q_out = {q_out[WIDTH-2:0], q_out[WIDTH-1]}; shift_cnt unchanged.
  - 101 rotate right. q_out = {q_out[0], q_out[WIDTH-1:1]}; shift_cnt unchanged.
  - 110 sync clear. q_out = 0; shift_cnt = 0.
  - 111 sync fill. q_out = all ones; shift_cnt = 0.
- full = (next shift_cnt == WIDTH). It is updated on the same edge as shift_cnt.
- shift_cnt never exceeds WIDTH. Further shifts continue to move data, and the counter stays at WIDTH.

## Timing
- Reset values: q_out = RESET_VAL, qcomp_out = ~RESET_VAL, shift_cnt = 0, full = 0. sout_msb and sout_lsb follow RESET_VAL.
- Synchronous latency: 1 cycle. Inputs sampled at edge N are visible on q_out, shift_cnt and full after edge N.
- qcomp_out, sout_msb and sout_lsb are combinational from q_out: zero added latency.
- Asynchronous path: reset or set assertion updates outputs within the same simulation time step, no clk needed.
- Release of reset or set: the first edge at which the control is sampled low performs the normal mode operation.
- reset and set both high: reset wins, q_out = RESET_VAL. If reset falls while set stays high, q_out goes to SET_VAL immediately.
- reset mid-shift sequence: shift_cnt is cleared. A partially assembled word is discarded and full never asserts for it.
- Illegal or unknown mode values do not exist. All 8 encodings are defined.

## Test plan
All scenarios use WIDTH = 8.
- **Async reset:** assert reset between clock edges while q_out = 8'hA5 → q_out = 8'h00 and full = 0 with no clk edge. Release reset, then load d = 8'h3C → q_out = 8'h3C after 1 edge.
- **Async set and priority:** pulse set with no clock → q_out = 8'hFF. Raise reset while set is high → q_out = 8'h00. Drop reset with set still high → q_out = 8'hFF.
- **SIPO fill:** load 8'h00, then 8 shift-left edges with sin = 1,0,1,1,0,0,1,0 → q_out = 8'hB2, shift_cnt = 8, full = 1 after the 8th edge. A 9th shift with sin = 1 → q_out = 8'h65 and shift_cnt stays at 8.
- **Rotate:** load 8'h81, rotate right once → 8'hC0. Rotate left twice → 8'h03. shift_cnt stays at 0.
- **Enable gating and sync clear/fill:** hold en = 0 with mode = 010 for 3 edges → q_out unchanged. mode 111 → 8'hFF, then mode 110 → 8'h00. qcomp_out is always ~q_out.
- **Reset mid-operation:** after 5 shifts (shift_cnt = 5), pulse reset → shift_cnt = 0. Then 7 more shifts → full = 0; the 8th shift → full = 1.
